imm_ext_arbiter: RTL
====================

Name: imm_ext_arbiter

Overview:
- Shares one registered immediate-extension unit between two requesters.
- Port A is the decode stage (I-type ALU/load/store immediates). Port B is the branch-target adder (branch offsets).
- Sequences each request through IDLE -> EXT and returns a 32-bit extended result to the granted requester.
- Supports zero-extend, sign-extend, LUI placement and branch-offset (sign-extend, shift left 2) modes.

Parameters:
- FAIR, 1: 1 = round-robin between A and B; 0 = fixed priority, A always wins.
- FIRST_A, 1: 1 = after reset, A wins the first simultaneous contest; 0 = B wins it.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: asynchronous, active-low reset.
- ReqA, input, 1: port A request; ImmA and ModeA are valid while high.
- ImmA, input, 16: port A immediate.
- ModeA, input, 2: port A extension mode.
- ReqB, input, 1: port B request.
- ImmB, input, 16: port B immediate.
- ModeB, input, 2: port B extension mode.
- GntA, output, 1: one-cycle pulse; the port A request was captured.
- GntB, output, 1: one-cycle pulse; the port B request was captured.
- OutA, output, 32: port A result, held until the next A result.
- OutValidA, output, 1: one-cycle pulse; OutA was updated.
- OutB, output, 32: port B result, held until the next B result.
- OutValidB, output, 1: one-cycle pulse; OutB was updated.
- Busy, output, 1: high while the FSM is in EXT.

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, all outputs=0, operand register=0, priority pointer set per FIRST_A. Any in-flight transaction is discarded and no OutValid is issued for it.
- FSM states: IDLE, EXT.
- IDLE, at a clock edge with ReqA|ReqB:
  - Select a winner.
  - Latch the winner's Imm/Mode and its identity into the operand register.
  - Register Gnt for the winner only.
  - Go to EXT.
- IDLE with no request: stay in IDLE; Gnt and OutValid stay 0.
- EXT (exactly one cycle):
  - Gnt for the winner is high, Busy=1.
  - At the end-of-cycle edge, compute the result from the operand register and register it into Out of the winner.
  - Pulse OutValid of the winner for the following cycle.
  - Return to IDLE.
  - Requests are not sampled in EXT.
- Latency: request sampled at edge N; Gnt high in cycle N+1; Out/OutValid valid in cycle N+2. Throughput is at most one transaction per 2 cycles.
- Requester rule: hold Req/Imm/Mode stable until Gnt is seen, then drop Req. A Req still high at the next IDLE sampling edge is treated as a new request. The data is already latched, so input changes after the grant edge have no effect.
- Arbitration:
  - Only one requesting: that port wins.
  - Both requesting, FAIR=1: the port not granted last wins; the pointer updates on every grant.
  - Both requesting, FAIR=0: A wins.
- Mode encoding (M = imm[15]):
  - 00: {16'h0000, imm}
  - 01: {{16{M}}, imm}
  - 10: {imm, 16'h0000}
  - 11: {{14{M}}, imm, 2'b00}
- Exclusivity: GntA & GntB and OutValidA & OutValidB are never simultaneously 1.
- Output holding: Out of the non-winner is unchanged by a transaction.
- Reset asserted during EXT: Out, OutValid and Gnt clear immediately. After release the FSM starts in IDLE; the first valid output is 2 cycles after the first sampled request.

Test Plan:
- Reset then single A request (ReqA=1, ImmA=16'h8001, ModeA=01), one cycle -> GntA at N+1; OutA=32'hFFFF8001 with OutValidA at N+2; B outputs stay 0.
- Mode sweep on B with ImmB=16'hFFFE:
  - 00 -> 32'h0000FFFE
  - 01 -> 32'hFFFFFFFE
  - 10 -> 32'hFFFE0000
  - 11 -> 32'hFFFFFFF8
  - ImmB=16'h0004, mode 11 -> 32'h00000010.
- FAIR=1, ReqA and ReqB held continuously -> grants alternate A, B, A, B on every second cycle; GntA/GntB never overlap.
- FAIR=0, both held -> GntA on every transaction and GntB never asserts. Dropping ReqA lets B win at the next IDLE edge.
- Hold-after-grant: change ImmA to 16'h1234 in the EXT cycle -> OutA reflects the originally latched value. OutB retains its prior value through A transactions.
- Assert Rst_n=0 mid-EXT -> Out*, OutValid*, Gnt* and Busy go to 0 before the next edge, with no OutValid pulse. After release, a new ReqB is granted normally with 2-cycle latency.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// Two-port arbiter in front of one registered immediate-extension unit.
// Each granted request takes one EXT cycle; results return on the winner's port only.
module imm_ext_arbiter #(
   parameter bit FAIR    = 1'b1,
   parameter bit FIRST_A = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        ReqA,
   input  logic [15:0] ImmA,
   input  logic [1:0]  ModeA,
   input  logic        ReqB,
   input  logic [15:0] ImmB,
   input  logic [1:0]  ModeB,
   output logic        GntA,
   output logic        GntB,
   output logic [31:0] OutA,
   output logic        OutValidA,
   output logic [31:0] OutB,
   output logic        OutValidB,
   output logic        Busy
);

   localparam logic StIdle = 1'b0;
   localparam logic StExt  = 1'b1;

   logic        state_q, state_d;
   logic [15:0] op_imm_q, op_imm_d;
   logic [1:0]  op_mode_q, op_mode_d;
   logic        op_b_q, op_b_d;
   logic        prefer_a_q, prefer_a_d;
   logic        gnt_a_q, gnt_a_d;
   logic        gnt_b_q, gnt_b_d;
   logic        vld_a_q, vld_a_d;
   logic        vld_b_q, vld_b_d;
   logic [31:0] out_a_q, out_a_d;
   logic [31:0] out_b_q, out_b_d;

   logic        win_b;
   logic        sign;
   logic [31:0] ext_res;

   // B wins only when A is idle, or on a tie when fair and A had the last grant.
   assign win_b = ReqB & (~ReqA | (FAIR & ~prefer_a_q));

   assign sign = op_imm_q[15];

   always_comb begin
      ext_res = 32'h0;
      unique case (op_mode_q)
         2'b00: ext_res = {16'h0000, op_imm_q};
         2'b01: ext_res = {{16{sign}}, op_imm_q};
         2'b10: ext_res = {op_imm_q, 16'h0000};
         2'b11: ext_res = {{14{sign}}, op_imm_q, 2'b00};
         default: ext_res = 32'h0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_imm_d   = op_imm_q;
      op_mode_d  = op_mode_q;
      op_b_d     = op_b_q;
      prefer_a_d = prefer_a_q;
      out_a_d    = out_a_q;
      out_b_d    = out_b_q;
      gnt_a_d    = 1'b0;
      gnt_b_d    = 1'b0;
      vld_a_d    = 1'b0;
      vld_b_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ReqA | ReqB) begin
               op_imm_d   = win_b ? ImmB : ImmA;
               op_mode_d  = win_b ? ModeB : ModeA;
               op_b_d     = win_b;
               gnt_a_d    = ~win_b;
               gnt_b_d    = win_b;
               prefer_a_d = win_b;
               state_d    = StExt;
            end
         end
         StExt: begin
            if (op_b_q) begin
               out_b_d = ext_res;
               vld_b_d = 1'b1;
            end else begin
               out_a_d = ext_res;
               vld_a_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= StIdle;
         op_imm_q   <= 16'h0;
         op_mode_q  <= 2'b00;
         op_b_q     <= 1'b0;
         prefer_a_q <= FIRST_A;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         vld_a_q    <= 1'b0;
         vld_b_q    <= 1'b0;
         out_a_q    <= 32'h0;
         out_b_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         op_imm_q   <= op_imm_d;
         op_mode_q  <= op_mode_d;
         op_b_q     <= op_b_d;
         prefer_a_q <= prefer_a_d;
         gnt_a_q    <= gnt_a_d;
         gnt_b_q    <= gnt_b_d;
         vld_a_q    <= vld_a_d;
         vld_b_q    <= vld_b_d;
         out_a_q    <= out_a_d;
         out_b_q    <= out_b_d;
      end
   end

   assign GntA      = gnt_a_q;
   assign GntB      = gnt_b_q;
   assign OutA      = out_a_q;
   assign OutB      = out_b_q;
   assign OutValidA = vld_a_q;
   assign OutValidB = vld_b_q;
   assign Busy      = (state_q == StExt);

endmodule
